i2c_accel_responder: RTL and testbench

//  I2C target (slave) that models the MPU-6050 accelerometer at 7-bit addr 0x68 (0xD0 wr / 0xD1 rd).

---
 rtl/i2c_accel_responder_if.sv | 9 +
 rtl/i2c_accel_responder.sv | 197 +++++++++++++++++++
 tb/tb_i2c_accel_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_accel_responder_if.sv
// Two-wire I2C bus between the accelerometer master model and the responder.
interface i2c_accel_responder_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_accel_responder.sv
// I2C target modelling the MPU-6050 register file (WHOAMI, PWR_MGMT_1, SIGNAL_PATH_RESET).
// Optional macro ACCEL_DATA_RAMP_EN: regs 59..72 become a read-only STOP counter ramp.
module i2c_accel_responder #(
    parameter logic [6:0]  DEV_ADDR   = 7'h68,
    parameter int unsigned FILT_LEN   = 3,
    parameter logic [7:0]  WHOAMI_VAL = 8'h68
) (
    input  logic                        clk_in,
    input  logic                        reset,
    i2c_accel_responder_if.slave        bus,
    output logic                        reg_wr_stb,
    output logic [6:0]                  reg_wr_addr,
    output logic [7:0]                  reg_wr_data,
    output logic                        busy,
    output logic [7:0]                  addr_nack
);
    localparam logic [6:0] REG_SIG_RST = 7'd104;
    localparam logic [6:0] REG_PWR     = 7'd107;
    localparam logic [6:0] REG_WHOAMI  = 7'd117;
    localparam logic [2:0] FILT_LAST   = 3'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_PTR, S_ACK_W, S_WR, S_RD, S_RD_ACK, S_IGNORE
    } state_t;

    function automatic logic [7:0] rst_val(input int i);
        return (i == int'(REG_PWR)) ? 8'h40 : 8'h00;
    endfunction

    logic [1:0] scl_s_q, sda_s_q;
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_prev_q, sda_prev_q;
    logic [2:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic [6:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d, nack_q, nack_d;
    logic       stb_q, stb_d, clr_q, clr_d, soft_rst_q, soft_rst_d;
    logic [7:0] regs_q [128];
    logic [7:0] regs_d [128];
    logic       scl_rise, scl_fall, start_c, stop_c, ramp_hit;
    logic [7:0] rd_byte, ramp_byte;

    assign scl_rise = scl_f_q & ~scl_prev_q;
    assign scl_fall = ~scl_f_q & scl_prev_q;
    assign start_c  = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign stop_c   = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;

`ifdef ACCEL_DATA_RAMP_EN
    logic [15:0] ramp_q, ramp_d;
    assign ramp_hit  = (ptr_q >= 7'd59) && (ptr_q <= 7'd72);
    // Odd addresses (59, 61, ...) carry the high byte of each word.
    assign ramp_byte = ptr_q[0] ? ramp_q[15:8] : ramp_q[7:0];
    always_comb ramp_d = stop_c ? ramp_q + 16'd1 : ramp_q;
    always_ff @(posedge clk_in) begin
        if (reset) ramp_q <= '0;
        else       ramp_q <= ramp_d;
    end
`else
    assign ramp_hit  = 1'b0;
    assign ramp_byte = 8'h00;
`endif

    always_comb begin
        if (ptr_q == REG_WHOAMI) rd_byte = WHOAMI_VAL;
        else if (ramp_hit)       rd_byte = ramp_byte;
        else                     rd_byte = regs_q[ptr_q];
    end

    // A filtered level changes only after FILT_LEN consecutive differing samples.
    always_comb begin
        scl_f_d = scl_f_q; scl_cnt_d = '0;
        sda_f_d = sda_f_q; sda_cnt_d = '0;
        if (scl_s_q[1] != scl_f_q) begin
            if (scl_cnt_q == FILT_LAST) scl_f_d = scl_s_q[1];
            else                        scl_cnt_d = scl_cnt_q + 3'd1;
        end
        if (sda_s_q[1] != sda_f_q) begin
            if (sda_cnt_q == FILT_LAST) sda_f_d = sda_s_q[1];
            else                        sda_cnt_d = sda_cnt_q + 3'd1;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;  bit_cnt_d = bit_cnt_q;  shift_d = shift_q;  rw_d = rw_q;
        ptr_d = ptr_q;  sda_oe_d = sda_oe_q;  busy_d = busy_q;  nack_d = nack_q;
        stb_d = 1'b0;  wr_addr_d = wr_addr_q;  wr_data_d = wr_data_q;
        clr_d = 1'b0;  soft_rst_d = 1'b0;
        regs_d = regs_q;
        if (clr_q) regs_d[REG_SIG_RST][2:0] = 3'b000;
        if (soft_rst_q) for (int i = 0; i < 128; i++) regs_d[i] = rst_val(i);

        if (start_c) begin
            state_d = S_ADDR;  bit_cnt_d = '0;  sda_oe_d = 1'b0;  busy_d = 1'b1;
        end else if (stop_c) begin
            state_d = S_IDLE;  sda_oe_d = 1'b0;  busy_d = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = S_ACK_W;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                rw_d    = shift_q[0];
                                state_d = S_ACK_A;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = S_IGNORE;
                                if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
                            end
                        end else if (state_q == S_PTR) begin
                            ptr_d = shift_q[6:0];
                        end else begin
                            stb_d = 1'b1;  wr_addr_d = ptr_q;  wr_data_d = shift_q;
                            ptr_d = ptr_q + 7'd1;
                            if (ptr_q != REG_WHOAMI && !ramp_hit) regs_d[ptr_q] = shift_q;
                            if (ptr_q == REG_SIG_RST) clr_d = 1'b1;
                            if (ptr_q == REG_PWR && shift_q[7]) soft_rst_d = 1'b1;
                        end
                    end
                end
                S_ACK_A: if (scl_fall) begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        state_d = S_RD;  shift_d = rd_byte;  sda_oe_d = ~rd_byte[7];
                    end else begin
                        state_d = S_PTR;  sda_oe_d = 1'b0;
                    end
                end
                S_ACK_W: if (scl_fall) begin
                    state_d = S_WR;  bit_cnt_d = '0;  sda_oe_d = 1'b0;
                end
                S_RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;  state_d = S_RD_ACK;
                        end else begin
                            sda_oe_d = ~shift_q[6];  shift_d = {shift_q[6:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    // bit_cnt 9 marks "master ACKed, load next byte on the coming fall".
                    if (scl_rise) begin
                        if (sda_f_q) state_d = S_IGNORE;
                        else begin
                            ptr_d = ptr_q + 7'd1;  bit_cnt_d = 4'd9;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        state_d = S_RD;  bit_cnt_d = '0;
                        shift_d = rd_byte;  sda_oe_d = ~rd_byte[7];
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            scl_s_q <= 2'b11;  sda_s_q <= 2'b11;
            scl_f_q <= 1'b1;  sda_f_q <= 1'b1;  scl_prev_q <= 1'b1;  sda_prev_q <= 1'b1;
            scl_cnt_q <= '0;  sda_cnt_q <= '0;
            state_q <= S_IDLE;  bit_cnt_q <= '0;  shift_q <= '0;  rw_q <= 1'b0;
            ptr_q <= '0;  sda_oe_q <= 1'b0;  busy_q <= 1'b0;  nack_q <= '0;
            stb_q <= 1'b0;  wr_addr_q <= '0;  wr_data_q <= '0;  clr_q <= 1'b0;  soft_rst_q <= 1'b0;
            // NOTE: the register file is flops, not RAM, because it has non-zero reset values and a soft reset.
            for (int i = 0; i < 128; i++) regs_q[i] <= rst_val(i);
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            scl_s_q <= {scl_s_q[0], bus.scl_in};  sda_s_q <= {sda_s_q[0], bus.sda_in};
            scl_f_q <= scl_f_d;  sda_f_q <= sda_f_d;  scl_prev_q <= scl_f_q;  sda_prev_q <= sda_f_q;
            scl_cnt_q <= scl_cnt_d;  sda_cnt_q <= sda_cnt_d;
            state_q <= state_d;  bit_cnt_q <= bit_cnt_d;  shift_q <= shift_d;  rw_q <= rw_d;
            ptr_q <= ptr_d;  sda_oe_q <= sda_oe_d;  busy_q <= busy_d;  nack_q <= nack_d;
            stb_q <= stb_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
            clr_q <= clr_d;  soft_rst_q <= soft_rst_d;
            regs_q <= regs_d;
        end
    end

    // Reset releases SDA combinationally so a stuck bus frees in the reset cycle itself.
    assign bus.sda_oe  = sda_oe_q & ~reset;
    assign reg_wr_stb  = stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;
    assign addr_nack   = nack_q;
endmodule

// File: tb/tb_i2c_accel_responder.sv
// Directed bench: an I2C master model drives the responder through reset, write, read and NACK cases.
module tb_i2c_accel_responder;
    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       reg_wr_stb;
    logic [6:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic [7:0] addr_nack;

    int errors = 0;
    int checks = 0;
    int q = 12;
    int stb_cnt = 0;
    logic [6:0] stb_addr = '0;
    logic [7:0] stb_data = '0;

    i2c_accel_responder_if bus();
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_accel_responder dut (
        .clk_in(clk_in), .reset(reset), .bus(bus),
        .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .busy(busy), .addr_nack(addr_nack)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (reg_wr_stb) begin
            stb_cnt  = stb_cnt + 1;
            stb_addr = reg_wr_addr;
            stb_data = reg_wr_data;
        end
    end

    typedef struct {
        logic       do_wr;
        logic [6:0] ra;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(q); scl_m = 1'b1; tick(q); sda_m = 1'b0; tick(q); scl_m = 1'b0; tick(q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(q); scl_m = 1'b1; tick(q); sda_m = 1'b1; tick(q);
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_m = b; tick(q); scl_m = 1'b1; tick(q); s = bus.sda_in; tick(q); scl_m = 1'b0; tick(q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    task automatic do_reset();
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tick(4); reset = 1'b0; tick(4);
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        int s0;

        vecs[0] = '{1'b1, 7'd5,   8'h3C, 8'h3C};
        vecs[1] = '{1'b1, 7'd0,   8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 7'd127, 8'h5A, 8'h5A};
        vecs[3] = '{1'b1, 7'd117, 8'h11, 8'h68};
        vecs[4] = '{1'b1, 7'd104, 8'hFF, 8'hF8};
        vecs[5] = '{1'b0, 7'd107, 8'h00, 8'h40};
        vecs[6] = '{1'b1, 7'd107, 8'hC1, 8'h40};
        vecs[7] = '{1'b0, 7'd5,   8'h00, 8'h00};
        vecs[8] = '{1'b0, 7'd127, 8'h00, 8'h00};
        vecs[9] = '{1'b0, 7'd104, 8'h00, 8'h00};

        do_reset();
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_nack", addr_nack, 0);
        check("rst_stb", reg_wr_stb, 0);
        check("rst_wr_addr", reg_wr_addr, 0);
        check("rst_wr_data", reg_wr_data, 0);

        // T1: write PWR_MGMT_1
        s0 = stb_cnt;
        i2c_start();
        check("t1_busy_after_start", busy, 1);
        write_byte(8'hD0, ack); check("t1_ack_addr", ack, 0);
        write_byte(8'h6B, ack); check("t1_ack_ptr", ack, 0);
        write_byte(8'h40, ack); check("t1_ack_data", ack, 0);
        check("t1_busy_before_stop", busy, 1);
        i2c_stop();
        check("t1_busy_after_stop", busy, 0);
        check("t1_stb_count", stb_cnt - s0, 1);
        check("t1_stb_addr", stb_addr, 107);
        check("t1_stb_data", stb_data, 8'h40);

        // T2: signal-path reset bits self-clear
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h68, ack); check("t2_ack_ptr", ack, 0);
        write_byte(8'h07, ack); check("t2_ack_data", ack, 0);
        i2c_stop();
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h68, ack);
        i2c_start();
        write_byte(8'hD1, ack); check("t2_ack_rd_addr", ack, 0);
        read_byte(1'b1, d); check("t2_rd_104", d, 8'h00);
        i2c_stop();

        // T3: WHO_AM_I
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h75, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b1, d); check("t3_whoami", d, 8'h68);
        check("t3_sda_released_after_nack", bus.sda_oe, 0);
        i2c_stop();
        check("t3_sda_idle", bus.sda_oe, 0);
        check("t3_busy_idle", busy, 0);

        // T5: pointer wrap on write and burst read
        s0 = stb_cnt;
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h7F, ack);
        write_byte(8'hAA, ack); check("t5_ack_aa", ack, 0);
        write_byte(8'h55, ack); check("t5_ack_55", ack, 0);
        i2c_stop();
        check("t5_stb_count", stb_cnt - s0, 2);
        check("t5_last_stb_addr", stb_addr, 0);
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h7F, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b0, d); check("t5_rd_127", d, 8'hAA);
        read_byte(1'b1, d); check("t5_rd_0_wrap", d, 8'h55);
        i2c_stop();

        // T4: foreign address is not acknowledged, nack count saturates
        s0 = stb_cnt;
        i2c_start();
        write_byte(8'hA0, ack); check("t4_no_ack", ack, 1);
        check("t4_addr_nack_1", addr_nack, 1);
        write_byte(8'h55, ack); check("t4_ignored_byte", ack, 1);
        i2c_stop();
        check("t4_no_stb", stb_cnt - s0, 0);
        q = 4;
        for (int n = 0; n < 299; n++) begin
            logic s;
            i2c_start();
            for (int i = 7; i >= 0; i--) bit_xfer(i == 7 || i == 5, s);
            i2c_stop();
        end
        q = 12;
        check("t4_addr_nack_sat", addr_nack, 255);

        // Reset while the responder drives a 0 data bit
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h75, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        check("mid_sda_driven", bus.sda_oe, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_release", bus.sda_oe, 0);
        do_reset();
        check("mid_rst_nack_clr", addr_nack, 0);
        check("mid_rst_busy", busy, 0);

        // Table: register rules
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].do_wr) begin
                s0 = stb_cnt;
                i2c_start();
                write_byte(8'hD0, ack);
                write_byte({1'b0, vecs[v].ra}, ack);
                write_byte(vecs[v].wd, ack);
                check($sformatf("vec%0d_wr_ack", v), ack, 0);
                i2c_stop();
                check($sformatf("vec%0d_stb_count", v), stb_cnt - s0, 1);
                check($sformatf("vec%0d_stb_addr", v), stb_addr, vecs[v].ra);
                check($sformatf("vec%0d_stb_data", v), stb_data, vecs[v].wd);
            end
            i2c_start();
            write_byte(8'hD0, ack);
            write_byte({1'b0, vecs[v].ra}, ack);
            i2c_start();
            write_byte(8'hD1, ack);
            read_byte(1'b1, d);
            i2c_stop();
            check($sformatf("vec%0d_rd", v), d, vecs[v].exp);
        end

        // T6: three empty transfers, then read regs 59..60
        do_reset();
        for (int n = 0; n < 3; n++) begin
            i2c_start();
            write_byte(8'hD0, ack);
            i2c_stop();
        end
        i2c_start();
        write_byte(8'hD0, ack);
        write_byte(8'h3B, ack);
        i2c_start();
        write_byte(8'hD1, ack);
        read_byte(1'b0, d); check("t6_rd_59", d, 8'h00);
        read_byte(1'b1, d);
`ifdef ACCEL_DATA_RAMP_EN
        check("t6_rd_60", d, 8'h03);
`else
        check("t6_rd_60", d, 8'h00);
`endif
        i2c_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
